// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types and encodings for the multi-cycle datapath
package dp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_PCT = 2'b11;

  localparam int A0_IDX = 10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/mc_datapath_if.sv
// rtl/mc_datapath_if.sv - data memory request/response bus
interface mc_datapath_if #(
  parameter int D_WIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [D_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [2:0]         mem_funct3;
  logic               mem_ack;
  logic [D_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU with zero and signed/unsigned less-than flags
module mc_alu import dp_pkg::*; #(
  parameter int D_WIDTH = 32
) (
  input  logic [3:0]         ctrl,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  output logic [D_WIDTH-1:0] y,
  output logic               zero,
  output logic               less,
  output logic               lessu
);
  localparam int SH = $clog2(D_WIDTH);

  logic [SH-1:0] shamt;

  assign shamt = b[SH-1:0];
  assign less  = $signed(a) < $signed(b);
  assign lessu = a < b;
  assign zero  = (y == '0);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(D_WIDTH-1){1'b0}}, less};
      ALU_SLTU: y = {{(D_WIDTH-1){1'b0}}, lessu};
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 2R1W register file, x0 hardwired to zero, async clear
module mc_regfile import dp_pkg::*; #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] ra1,
  input  logic [A_WIDTH-1:0] ra2,
  input  logic               we,
  input  logic [A_WIDTH-1:0] wa,
  input  logic [D_WIDTH-1:0] wd,
  output logic [D_WIDTH-1:0] rd1,
  output logic [D_WIDTH-1:0] rd2,
  output logic [D_WIDTH-1:0] a0
);
  localparam int N = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] A0_ADDR = A_WIDTH'(A0_IDX);

  logic [D_WIDTH-1:0] regs [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
  assign a0  = regs[A0_ADDR];
endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle IDLE/EXEC/MEM/WB datapath around ALU and register file
module mc_datapath import dp_pkg::*; #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  output logic               done,
  input  logic               MemWrite,
  input  logic               RegWrite,
  input  logic [3:0]         ALUctrl,
  input  logic               ALUSrc,
  input  logic [1:0]         ResultSrc,
  input  logic [2:0]         funct3_i,
  input  logic [A_WIDTH-1:0] rs1,
  input  logic [A_WIDTH-1:0] rs2,
  input  logic [A_WIDTH-1:0] rd,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic [D_WIDTH-1:0] inc_PC,
  input  logic [D_WIDTH-1:0] PCTarget,
  output logic               Zero,
  output logic               Less,
  output logic               LessU,
  output logic [D_WIDTH-1:0] a0,
  mc_datapath_if.master      mem
);
  state_t state, state_nx;

  logic               mem_write_q, reg_write_q, alu_src_q;
  logic [3:0]         alu_ctrl_q;
  logic [1:0]         res_src_q;
  logic [2:0]         funct3_q;
  logic [A_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [D_WIDTH-1:0] imm_q, inc_pc_q, pc_target_q, alu_q, rd2_q, rdata_q;
  logic [D_WIDTH-1:0] rd1, rd2, op_b, alu_y, wb_data;
  logic               alu_zero, alu_less, alu_lessu, rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Memory-side outputs decode from registered state so reset drops mem_req at once.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = (mem_write_q || res_src_q == RES_MEM) ? S_MEM : S_WB;
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = mem_write_q;
        if (mem.mem_ack) state_nx = S_WB;
      end
      S_WB: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem.mem_addr   = alu_q;
  assign mem.mem_wdata  = rd2_q;
  assign mem.mem_funct3 = funct3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write_q <= 1'b0; reg_write_q <= 1'b0; alu_src_q <= 1'b0;
      alu_ctrl_q  <= '0;   res_src_q   <= '0;   funct3_q  <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      imm_q <= '0; inc_pc_q <= '0; pc_target_q <= '0;
      alu_q <= '0; rd2_q <= '0; rdata_q <= '0;
      Zero  <= 1'b0; Less <= 1'b0; LessU <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mem_write_q <= MemWrite; reg_write_q <= RegWrite; alu_src_q <= ALUSrc;
          alu_ctrl_q  <= ALUctrl;  res_src_q   <= ResultSrc; funct3_q <= funct3_i;
          rs1_q <= rs1; rs2_q <= rs2; rd_q <= rd;
          imm_q <= ImmExt; inc_pc_q <= inc_PC; pc_target_q <= PCTarget;
        end
        S_EXEC: begin
          alu_q <= alu_y;
          rd2_q <= rd2;
          Zero  <= alu_zero;
          Less  <= alu_less;
          LessU <= alu_lessu;
        end
        S_MEM: if (mem.mem_ack) rdata_q <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  assign op_b  = alu_src_q ? imm_q : rd2;
  assign rf_we = (state == S_WB) && reg_write_q && (rd_q != '0);

  always_comb begin
    wb_data = alu_q;
    case (res_src_q)
      RES_ALU: wb_data = alu_q;
      RES_MEM: wb_data = rdata_q;
      RES_PC4: wb_data = inc_pc_q;
      RES_PCT: wb_data = pc_target_q;
      default: wb_data = alu_q;
    endcase
  end

  mc_regfile #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(rs1_q), .ra2(rs2_q),
    .we(rf_we), .wa(rd_q), .wd(wb_data),
    .rd1(rd1), .rd2(rd2), .a0(a0)
  );

  mc_alu #(.D_WIDTH(D_WIDTH)) u_alu (
    .ctrl(alu_ctrl_q), .a(rd1), .b(op_b),
    .y(alu_y), .zero(alu_zero), .less(alu_less), .lessu(alu_lessu)
  );
endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - directed self-checking bench for mc_datapath
module tb_mc_datapath;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, ready, done;
  logic        MemWrite, RegWrite, ALUSrc;
  logic [3:0]  ALUctrl;
  logic [1:0]  ResultSrc;
  logic [2:0]  funct3_i;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmExt, inc_PC, PCTarget, a0;
  logic        Zero, Less, LessU;

  int checks = 0;
  int failures = 0;

  int          lat, req_cyc, dones;
  bit          stable, rdy_after;
  logic [31:0] s_addr, s_wdata, v;
  logic        s_we;
  logic [2:0]  s_f3;

  always #5 clk = ~clk;

  mc_datapath_if #(.D_WIDTH(32)) mem ();

  mc_datapath #(.A_WIDTH(5), .D_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .done(done),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUSrc(ALUSrc),
    .ResultSrc(ResultSrc), .funct3_i(funct3_i), .rs1(rs1), .rs2(rs2), .rd(rd),
    .ImmExt(ImmExt), .inc_PC(inc_PC), .PCTarget(PCTarget),
    .Zero(Zero), .Less(Less), .LessU(LessU), .a0(a0), .mem(mem)
  );

  // Called at a negedge; start is sampled at the next posedge. Returns at a negedge.
  task automatic run_instr(
    input logic mw, input logic rw, input logic [3:0] ctl, input logic asrc,
    input logic [1:0] rsrc, input logic [2:0] f3,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
    input logic [31:0] imm, input logic [31:0] pc4, input logic [31:0] pct,
    input int ack_dly, input logic [31:0] load_val, input bit poke, input bit stray_ack);
    int done_n;
    MemWrite = mw; RegWrite = rw; ALUctrl = ctl; ALUSrc = asrc; ResultSrc = rsrc;
    funct3_i = f3; rs1 = r1; rs2 = r2; rd = rdd; ImmExt = imm; inc_PC = pc4; PCTarget = pct;
    start = 1'b1;
    @(posedge clk);
    lat = -1; req_cyc = 0; dones = 0; stable = 1'b1; rdy_after = 1'b0; done_n = -1;
    s_addr = '0; s_wdata = '0; s_we = 1'b0; s_f3 = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem.mem_req) begin
        if (req_cyc == 0) begin
          s_addr = mem.mem_addr; s_wdata = mem.mem_wdata; s_we = mem.mem_we; s_f3 = mem.mem_funct3;
        end else if (s_addr !== mem.mem_addr || s_wdata !== mem.mem_wdata ||
                     s_we !== mem.mem_we || s_f3 !== mem.mem_funct3) begin
          stable = 1'b0;
        end
        req_cyc++;
        mem.mem_ack   = (req_cyc == ack_dly);
        mem.mem_rdata = (req_cyc == ack_dly) ? load_val : 32'hDEADBEEF;
      end else begin
        mem.mem_ack   = stray_ack;
        mem.mem_rdata = 32'hBAD0BAD0;
      end
      if (done) begin
        dones++;
        if (done_n < 0) begin done_n = n; lat = n + 1; end
      end
      if (done_n >= 0 && n == done_n + 1) rdy_after = ready;
      start = poke && !done && !ready && done_n < 0;
      if (done_n >= 0 && n == done_n + 3) break;
    end
    start = 1'b0;
    mem.mem_ack = 1'b0;
  endtask

  task automatic alu_op(input logic [3:0] ctl, input logic asrc, input logic rw,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                        input logic [31:0] imm);
    run_instr(1'b0, rw, ctl, asrc, RES_ALU, 3'b000, r1, r2, rdd, imm, 32'h0, 32'h0,
              0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
    alu_op(ALU_ADD, 1'b0, 1'b1, r, 5'd0, 5'd10, 32'h0);
    val = a0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", mem.mem_req); end
    checks++; if (mem.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", mem.mem_we); end
    checks++; if (a0 !== 32'h0) begin failures++; $display("FAIL reset_a0: got %h expected 0", a0); end
    checks++; if ({Zero, Less, LessU} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {Zero, Less, LessU}); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_ALU, 3'b000, 5'd0, 5'd0, 5'd10, 32'd5,
              32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    checks++; if (lat !== 2) begin failures++; $display("FAIL addi_latency: got %0d expected 2", lat); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL addi_done_count: got %0d expected 1", dones); end
    checks++; if (a0 !== 32'd5) begin failures++; $display("FAIL addi_a0: got %h expected 5", a0); end
    checks++; if (req_cyc !== 0) begin failures++; $display("FAIL addi_no_mem_req: got %0d expected 0", req_cyc); end
    checks++; if (rdy_after !== 1'b1) begin failures++; $display("FAIL addi_ready_after_done: got %b expected 1", rdy_after); end
  endtask

  task automatic test_wrap_flags;
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF);
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'h1);
    alu_op(ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd1, 5'd2, 32'h0);
    alu_op(ALU_SUB, 1'b0, 1'b0, 5'd1, 5'd3, 5'd0, 32'h0);
    checks++; if ({Zero, Less, LessU} !== 3'b010) begin failures++; $display("FAIL flags_m1_vs_1: got %b expected 010", {Zero, Less, LessU}); end
    repeat (3) @(negedge clk);
    checks++; if ({Zero, Less, LessU} !== 3'b010) begin failures++; $display("FAIL flags_hold: got %b expected 010", {Zero, Less, LessU}); end
    alu_op(ALU_SUB, 1'b0, 1'b0, 5'd3, 5'd1, 5'd0, 32'h0);
    checks++; if ({Zero, Less, LessU} !== 3'b001) begin failures++; $display("FAIL flags_1_vs_m1: got %b expected 001", {Zero, Less, LessU}); end
    alu_op(ALU_SUB, 1'b0, 1'b0, 5'd1, 5'd1, 5'd0, 32'h0);
    checks++; if ({Zero, Less, LessU} !== 3'b100) begin failures++; $display("FAIL flags_equal: got %b expected 100", {Zero, Less, LessU}); end
    read_reg(5'd2, v);
    checks++; if (v !== 32'hFFFFFFFE) begin failures++; $display("FAIL add_wrap_x2: got %h expected fffffffe", v); end
  endtask

  task automatic test_sw_lw;
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'h100);
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 32'hCAFEBABE);
    run_instr(1'b1, 1'b0, ALU_ADD, 1'b1, RES_ALU, 3'b010, 5'd5, 5'd6, 5'd0, 32'h0,
              32'h0, 32'h0, 3, 32'h0, 1'b0, 1'b0);
    checks++; if (lat !== 5) begin failures++; $display("FAIL sw_latency: got %0d expected 5", lat); end
    checks++; if (req_cyc !== 3) begin failures++; $display("FAIL sw_req_cycles: got %0d expected 3", req_cyc); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL sw_req_stable: got %b expected 1", stable); end
    checks++; if (s_addr !== 32'h100) begin failures++; $display("FAIL sw_addr: got %h expected 100", s_addr); end
    checks++; if (s_wdata !== 32'hCAFEBABE) begin failures++; $display("FAIL sw_wdata: got %h expected cafebabe", s_wdata); end
    checks++; if (s_we !== 1'b1 || s_f3 !== 3'b010) begin failures++; $display("FAIL sw_we_funct3: got %b/%b expected 1/010", s_we, s_f3); end
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_MEM, 3'b010, 5'd5, 5'd0, 5'd10, 32'h4,
              32'h0, 32'h0, 3, 32'h12345678, 1'b0, 1'b0);
    checks++; if (lat !== 5) begin failures++; $display("FAIL lw_latency: got %0d expected 5", lat); end
    checks++; if (req_cyc !== 3 || stable !== 1'b1) begin failures++; $display("FAIL lw_req: got %0d/%b expected 3/1", req_cyc, stable); end
    checks++; if (s_addr !== 32'h104 || s_we !== 1'b0) begin failures++; $display("FAIL lw_addr_we: got %h/%b expected 104/0", s_addr, s_we); end
    checks++; if (a0 !== 32'h12345678) begin failures++; $display("FAIL lw_a0: got %h expected 12345678", a0); end
  endtask

  task automatic test_result_src;
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_PC4, 3'b000, 5'd0, 5'd0, 5'd10, 32'h0,
              32'h44, 32'h80, 0, 32'h0, 1'b0, 1'b0);
    checks++; if (a0 !== 32'h44) begin failures++; $display("FAIL res_pc4: got %h expected 44", a0); end
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_PCT, 3'b000, 5'd0, 5'd0, 5'd10, 32'h0,
              32'h44, 32'h80, 0, 32'h0, 1'b0, 1'b0);
    checks++; if (a0 !== 32'h80) begin failures++; $display("FAIL res_pctarget: got %h expected 80", a0); end
    run_instr(1'b0, 1'b0, ALU_ADD, 1'b1, RES_PCT, 3'b000, 5'd0, 5'd0, 5'd10, 32'h0,
              32'h44, 32'h99, 0, 32'h0, 1'b0, 1'b0);
    checks++; if (a0 !== 32'h80) begin failures++; $display("FAIL regwrite_off: got %h expected 80", a0); end
  endtask

  task automatic test_x0_and_ignore;
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h7);
    read_reg(5'd0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL x0_write_discarded: got %h expected 0", v); end
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_MEM, 3'b010, 5'd0, 5'd0, 5'd10, 32'h20,
              32'h0, 32'h0, 2, 32'h0000ABCD, 1'b1, 1'b0);
    checks++; if (dones !== 1 || lat !== 4) begin failures++; $display("FAIL poke_mem_done: got %0d/%0d expected 1/4", dones, lat); end
    checks++; if (a0 !== 32'h0000ABCD) begin failures++; $display("FAIL poke_mem_a0: got %h expected 0000abcd", a0); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL poke_mem_idle: got %b expected 1", ready); end
    run_instr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_ALU, 3'b000, 5'd0, 5'd0, 5'd10, 32'h3,
              32'h0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    checks++; if (dones !== 1 || a0 !== 32'h3) begin failures++; $display("FAIL poke_exec: got %0d/%h expected 1/3", dones, a0); end
  endtask

  task automatic test_reset_mid_mem;
    MemWrite = 1'b0; RegWrite = 1'b1; ALUctrl = ALU_ADD; ALUSrc = 1'b1; ResultSrc = RES_MEM;
    funct3_i = 3'b010; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd7; ImmExt = 32'h40;
    mem.mem_ack = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (mem.mem_req !== 1'b1) begin failures++; $display("FAIL abort_in_mem: got %b expected 1", mem.mem_req); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem.mem_req !== 1'b0 || mem.mem_we !== 1'b0) begin failures++; $display("FAIL abort_mem_req: got %b/%b expected 0/0", mem.mem_req, mem.mem_we); end
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_ready_done: got %b/%b expected 1/0", ready, done); end
    checks++; if (a0 !== 32'h0) begin failures++; $display("FAIL abort_a0_cleared: got %h expected 0", a0); end
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(5'd7, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL abort_no_write: got %h expected 0", v); end
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'd9);
    checks++; if (a0 !== 32'd9 || lat !== 2) begin failures++; $display("FAIL after_abort: got %h/%0d expected 9/2", a0, lat); end
  endtask

  task automatic test_back_to_back;
    int cnt;
    alu_op(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'h0);
    MemWrite = 1'b0; RegWrite = 1'b1; ALUctrl = ALU_ADD; ALUSrc = 1'b1; ResultSrc = RES_ALU;
    rs1 = 5'd10; rs2 = 5'd0; rd = 5'd10; ImmExt = 32'h1;
    start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    start = 1'b0;
    checks++; if (cnt !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d expected 3", cnt); end
    checks++; if (a0 !== 32'h3) begin failures++; $display("FAIL b2b_a0: got %h expected 3", a0); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    MemWrite = 1'b0; RegWrite = 1'b0; ALUctrl = '0; ALUSrc = 1'b0; ResultSrc = '0;
    funct3_i = '0; rs1 = '0; rs2 = '0; rd = '0; ImmExt = '0; inc_PC = '0; PCTarget = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    test_reset;
    test_addi;
    test_wrap_flags;
    test_sw_lw;
    test_result_src;
    test_x0_and_ignore;
    test_reset_mid_mem;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
